// File: rtl/tl_pkg.sv
// Shared traffic-light encodings and lane indexing, used by both the
// light controller and the traffic model.
package tl_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    LEFT   = 2'b10,
    RED    = 2'b11
  } light_e;

  localparam int NUM_LANES = 4;
  localparam int TMR_W     = 4;

  localparam int LANE_A  = 0;
  localparam int LANE_AL = 1;
  localparam int LANE_B  = 2;
  localparam int LANE_BL = 3;

  // A straight lane moves on GREEN and a left-turn lane on LEFT.
  // YELLOW and RED hold every lane.
  function automatic logic lane_permit(input logic [1:0] light, input logic is_left);
    return light == (is_left ? LEFT : GREEN);
  endfunction

endpackage

// File: rtl/tl_lane_queue.sv
// One lane: saturating vehicle count plus a departure timer that paces
// vehicles out while the lane is permitted.
module tl_lane_queue
  import tl_pkg::*;
#(
  parameter int QW         = 4,
  parameter int DEPART_GAP = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr,
  input  logic          permit,
  output logic [QW-1:0] count,
  output logic          occupied,
  output logic          drop
);

  localparam logic [QW-1:0]    CNT_MAX  = {QW{1'b1}};
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(DEPART_GAP - 1);

  logic [QW-1:0]    count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             active, dep;

  // The timer only runs while a vehicle can actually leave; any break
  // in permission discards partial progress.
  assign active = permit && (count_q != '0);
  assign dep    = active && (timer_q == GAP_LAST);

  always_comb begin
    timer_d = '0;
    count_d = count_q;
    drop    = 1'b0;
    if (active && !dep) timer_d = timer_q + TMR_W'(1);
    if (arr && !dep) begin
      if (count_q == CNT_MAX) drop = 1'b1;
      else                    count_d = count_q + QW'(1);
    end else if (dep && !arr) begin
      count_d = count_q - QW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      timer_q <= '0;
    end else begin
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  assign count    = count_q;
  assign occupied = |count_q;

endmodule

// File: rtl/tl_traffic_model.sv
// Four-lane intersection traffic model: decodes light permissions, runs
// one queue per lane and keeps a sticky overflow flag.
module tl_traffic_model
  import tl_pkg::*;
#(
  parameter int QW         = 4,
  parameter int DEPART_GAP = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  input  logic          arr_a,
  input  logic          arr_al,
  input  logic          arr_b,
  input  logic          arr_bl,
  output logic          Ta,
  output logic          Tal,
  output logic          Tb,
  output logic          Tbl,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qal,
  output logic [QW-1:0] qb,
  output logic [QW-1:0] qbl,
  output logic          ovf
);

  logic [NUM_LANES-1:0]         arr_v, permit_v, occ_v, drop_v;
  logic [NUM_LANES-1:0][QW-1:0] cnt_v;
  logic                         ovf_q, ovf_d;

  assign arr_v = {arr_bl, arr_b, arr_al, arr_a};

  always_comb begin
    permit_v          = '0;
    permit_v[LANE_A]  = lane_permit(La, 1'b0);
    permit_v[LANE_AL] = lane_permit(La, 1'b1);
    permit_v[LANE_B]  = lane_permit(Lb, 1'b0);
    permit_v[LANE_BL] = lane_permit(Lb, 1'b1);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tl_lane_queue #(
      .QW         (QW),
      .DEPART_GAP (DEPART_GAP)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .arr      (arr_v[g]),
      .permit   (permit_v[g]),
      .count    (cnt_v[g]),
      .occupied (occ_v[g]),
      .drop     (drop_v[g])
    );
  end

  assign ovf_d = ovf_q | (|drop_v);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign qa  = cnt_v[LANE_A];
  assign qal = cnt_v[LANE_AL];
  assign qb  = cnt_v[LANE_B];
  assign qbl = cnt_v[LANE_BL];
  assign Ta  = occ_v[LANE_A];
  assign Tal = occ_v[LANE_AL];
  assign Tb  = occ_v[LANE_B];
  assign Tbl = occ_v[LANE_BL];
  assign ovf = ovf_q;

endmodule

// File: doc/tl_traffic_model.md
TL_TRAFFIC_MODEL -- requirements
Module: tl_traffic_model

Interface
REQ-001 Parameter QW, default 4, sets the width of each lane queue counter.
REQ-002 Parameter DEPART_GAP, default 2, sets the cycles per vehicle departure while a lane is permitted; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 La  input  2  light shown to road A (GREEN=2'b00, YELLOW=2'b01, LEFT=2'b10, RED=2'b11).
REQ-006 Lb  input  2  light shown to road B, same encoding as La.
REQ-007 arr_a, arr_al, arr_b, arr_bl  input  1 each  one-cycle vehicle arrival pulses per lane: A straight, A left, B straight, B left.
REQ-008 Ta, Tal, Tb, Tbl  output  1 each  lane-occupied sensors that feed the controller.
REQ-009 qa, qal, qb, qbl  output  QW each  current lane queue depths.
REQ-010 ovf  output  1  sticky flag, set when any arrival is dropped.

Function
REQ-011 Each lane SHALL hold a saturating queue count and a departure timer (4 bits).
REQ-012 Permission mapping SHALL be:
- A straight: La==GREEN
- A left: La==LEFT
- B straight: Lb==GREEN
- B left: Lb==LEFT
- YELLOW and RED permit no lane.
REQ-013 While a lane is permitted and its count is nonzero, its timer SHALL increment each cycle.
REQ-014 When the timer equals DEPART_GAP-1, a departure SHALL occur that cycle and the timer SHALL return to 0.
REQ-015 The first departure SHALL decrement the count on the DEPART_GAP-th rising edge after permission begins.
REQ-016 When a lane is not permitted or its count is 0, its timer SHALL clear to 0 on the next edge; partial progress is discarded.
REQ-017 An arrival alone SHALL increment the count by 1.
REQ-018 A departure alone SHALL decrement the count by 1.
REQ-019 An arrival and a departure in the same cycle SHALL leave the count unchanged.
REQ-020 An arrival at count 2^QW-1 with no same-cycle departure SHALL be dropped: count holds and ovf is set.
REQ-021 ovf SHALL stay set until reset.
REQ-022 No departure SHALL occur at count 0, so the count never wraps below zero.
REQ-023 Each sensor output SHALL be the OR-reduction of its lane's registered count, with no additional latency (e.g. Ta = |qa).
REQ-024 Lanes SHALL operate fully independently; several lanes may depart in the same cycle.
REQ-025 Light codes change at any cycle; the model SHALL respond only through REQ-012..REQ-016 and never glitch counts.

Reset
REQ-026 Asserting reset SHALL immediately clear all counts, timers and ovf; Ta, Tal, Tb, Tbl, qa, qal, qb, qbl and ovf all read 0.
REQ-027 Reset asserted mid-departure SHALL abort it; arrivals during reset SHALL be ignored.
REQ-028 After reset deasserts, the first update SHALL occur on the next rising clk edge.

Structure
REQ-029 Light encodings (GREEN, YELLOW, LEFT, RED) SHALL live in shared package tl_pkg, which the traffic light controller also uses.
REQ-030 One sub-module, tl_lane_queue, SHALL implement the behaviour of a single lane:
- inputs: clk, reset, arr, permit
- outputs: count, occupied, drop
REQ-031 tl_traffic_model SHALL instantiate tl_lane_queue four times, plus permission decode and the ovf register.

Verification
REQ-032 Reset, then 3 arr_a pulses with La=RED: qa=3 and Ta=1; qa stays 3 for 20 cycles.
REQ-033 With qa=3, set La=GREEN, DEPART_GAP=2: qa reads 2, 1, 0 at edges 2, 4 and 6; Ta falls with qa=0.
REQ-034 Set La=GREEN, then switch to YELLOW one cycle before the first departure: qa unchanged; the timer restarts from 0 on the next GREEN.
REQ-035 Hold arr_bl high for 17 cycles with Lb=RED: qbl saturates at 15 and ovf=1 from the 16th arrival onward.
REQ-036 With qal=1, La=LEFT and an arrival on the departure cycle: qal stays 1 and Tal stays 1.
REQ-037 Assert reset while all lanes are nonzero and mid-timer: all outputs are 0 immediately, before the next clk edge.
